// File: rtl/parking_ctrl_if.sv
// Request/status bundle between a parking-lot controller and its sensors/display.
// The master drives the entry/exit sensors; the slave (controller) drives lot status and pulses.
interface parking_ctrl_if #(
    parameter int unsigned N_SPOTS = 8,
    parameter int unsigned IDX_W   = $clog2(N_SPOTS)
);
    logic               enter_req;
    logic               exit_req;
    logic [IDX_W-1:0]   exit_idx;
    logic [N_SPOTS-1:0] occupancy;
    logic [IDX_W:0]     count;
    logic               full;
    logic               empty;
    logic               door_open;
    logic               busy;
    logic               assign_valid;
    logic [IDX_W-1:0]   assign_idx;
    logic               reject;
    logic               exit_err;

    modport master (
        output enter_req, exit_req, exit_idx,
        input  occupancy, count, full, empty, door_open, busy,
        input  assign_valid, assign_idx, reject, exit_err
    );

    modport slave (
        input  enter_req, exit_req, exit_idx,
        output occupancy, count, full, empty, door_open, busy,
        output assign_valid, assign_idx, reject, exit_err
    );
endinterface

// File: rtl/parking_ctrl.sv
// Parking-lot controller: allocates the lowest free spot on entry, frees spots on exit,
// and holds the door open for DOOR_CYCLES cycles after every accepted event.
module parking_ctrl #(
    parameter int unsigned N_SPOTS     = 8,
    parameter int unsigned DOOR_CYCLES = 4,
    parameter int unsigned IDX_W       = $clog2(N_SPOTS)
) (
    input  logic           clk,
    input  logic           rst_n,
    parking_ctrl_if.slave  bus
);

    localparam int unsigned     HoldW    = $clog2(DOOR_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(DOOR_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);
    localparam logic [IDX_W:0]   CntFull  = (IDX_W + 1)'(N_SPOTS);
    localparam logic [IDX_W:0]   CntOne   = (IDX_W + 1)'(1);

    typedef enum logic {StIdle, StDoor} state_e;

    state_e             state_q, state_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [N_SPOTS-1:0] occ_q, occ_d;
    logic [IDX_W:0]     count_q, count_d;
    logic [IDX_W-1:0]   aidx_q, aidx_d;
    logic               av_q, av_d;
    logic               rej_q, rej_d;
    logic               err_q, err_d;

    logic [IDX_W-1:0]   free_idx;
    logic               exit_ok;
    logic               full;

    // Scan downward so the last hit is the lowest clear bit.
    always_comb begin
        free_idx = '0;
        for (int i = int'(N_SPOTS) - 1; i >= 0; i--) begin
            if (!occ_q[i]) free_idx = IDX_W'(i);
        end
    end

    assign full    = (count_q == CntFull);
    assign exit_ok = (32'(bus.exit_idx) < N_SPOTS) && occ_q[bus.exit_idx];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        occ_d   = occ_q;
        count_d = count_q;
        aidx_d  = aidx_q;
        av_d    = 1'b0;
        rej_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                // Exit wins over a simultaneous entry; the entry is simply dropped.
                if (bus.exit_req) begin
                    if (exit_ok) begin
                        occ_d[bus.exit_idx] = 1'b0;
                        count_d             = count_q - CntOne;
                        hold_d              = HoldLoad;
                        state_d             = StDoor;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.enter_req) begin
                    if (full) begin
                        rej_d = 1'b1;
                    end else begin
                        occ_d[free_idx] = 1'b1;
                        count_d         = count_q + CntOne;
                        aidx_d          = free_idx;
                        av_d            = 1'b1;
                        hold_d          = HoldLoad;
                        state_d         = StDoor;
                    end
                end
            end
            StDoor: begin
                if (hold_q == '0) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q - HoldOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
            occ_q   <= '0;
            count_q <= '0;
            aidx_q  <= '0;
            av_q    <= 1'b0;
            rej_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            occ_q   <= occ_d;
            count_q <= count_d;
            aidx_q  <= aidx_d;
            av_q    <= av_d;
            rej_q   <= rej_d;
            err_q   <= err_d;
        end
    end

    assign bus.occupancy    = occ_q;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = (count_q == '0);
    assign bus.door_open    = (state_q == StDoor);
    assign bus.busy         = (state_q == StDoor);
    assign bus.assign_valid = av_q;
    assign bus.assign_idx   = aidx_q;
    assign bus.reject       = rej_q;
    assign bus.exit_err     = err_q;

endmodule

// File: tb/tb_parking_ctrl.sv
// Bench for parking_ctrl: directed vector table, hand-written corner sequences, and
// randomized traffic checked against a spot-array reference model.
module tb_parking_ctrl;
    localparam int N = 8;
    localparam int D = 4;
    localparam int W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    parking_ctrl_if #(.N_SPOTS(N), .IDX_W(W)) bus ();

    parking_ctrl #(.N_SPOTS(N), .DOOR_CYCLES(D), .IDX_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: spot array plus remaining door cycles.
    logic [N-1:0] m_occ;
    int           m_door;
    int           m_aidx;
    bit           m_av, m_rej, m_err;

    task automatic model_reset();
        m_occ  = '0;
        m_door = 0;
        m_aidx = 0;
        m_av   = 0;
        m_rej  = 0;
        m_err  = 0;
    endtask

    task automatic model_edge(input bit e, input bit x, input int idx);
        m_av  = 0;
        m_rej = 0;
        m_err = 0;
        if (m_door > 0) begin
            m_door--;
        end else if (x) begin
            if (idx < N && m_occ[idx]) begin
                m_occ[idx] = 1'b0;
                m_door     = D;
            end else begin
                m_err = 1;
            end
        end else if (e) begin
            if ($countones(m_occ) == N) begin
                m_rej = 1;
            end else begin
                int k;
                k = 0;
                while (m_occ[k]) k++;
                m_occ[k] = 1'b1;
                m_aidx   = k;
                m_av     = 1;
                m_door   = D;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit e, input bit x, input int idx);
        bus.enter_req = e;
        bus.exit_req  = x;
        bus.exit_idx  = W'(idx);
    endtask

    task automatic step();
        bit e, x;
        int idx;
        e   = bus.enter_req;
        x   = bus.exit_req;
        idx = int'(bus.exit_idx);
        @(posedge clk);
        model_edge(e, x, idx);
        #1;
    endtask

    task automatic check_model(input string tag);
        int c;
        c = $countones(m_occ);
        chk({tag, ".occ"},   bus.occupancy,    int'(m_occ));
        chk({tag, ".count"}, bus.count,        c);
        chk({tag, ".full"},  bus.full,         int'(c == N));
        chk({tag, ".empty"}, bus.empty,        int'(c == 0));
        chk({tag, ".door"},  bus.door_open,    int'(m_door > 0));
        chk({tag, ".busy"},  bus.busy,         int'(m_door > 0));
        chk({tag, ".av"},    bus.assign_valid, int'(m_av));
        chk({tag, ".aidx"},  bus.assign_idx,   m_aidx);
        chk({tag, ".rej"},   bus.reject,       int'(m_rej));
        chk({tag, ".err"},   bus.exit_err,     int'(m_err));
    endtask

    // Reset asserted between clock edges; outputs must clear before any edge.
    task automatic do_reset();
        drive(0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("reset");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit e;
        bit x;
        int idx;
        int occ;
        int cnt;
        bit av;
        int aidx;
        bit rej;
        bit err;
        bit busy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1, 0, 0, 8'h01, 1, 1, 0, 0, 0, 1};
        tbl[1]  = '{0, 0, 0, 8'h01, 1, 0, 0, 0, 0, 1};
        tbl[2]  = '{0, 0, 0, 8'h01, 1, 0, 0, 0, 0, 1};
        tbl[3]  = '{0, 0, 0, 8'h01, 1, 0, 0, 0, 0, 1};
        tbl[4]  = '{0, 0, 0, 8'h01, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 2, 8'h01, 1, 0, 0, 0, 1, 0};
        tbl[6]  = '{1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1};
        tbl[7]  = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{1, 0, 0, 8'h01, 1, 1, 0, 0, 0, 1};

        drive(0, 0, 0);
        model_reset();
        do_reset();

        // Directed vectors: first entry, bad exit, exit-beats-entry, requests during door.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].e, tbl[i].x, tbl[i].idx);
            step();
            chk($sformatf("vec%0d.occ", i),   bus.occupancy,    tbl[i].occ);
            chk($sformatf("vec%0d.count", i), bus.count,        tbl[i].cnt);
            chk($sformatf("vec%0d.av", i),    bus.assign_valid, int'(tbl[i].av));
            chk($sformatf("vec%0d.aidx", i),  bus.assign_idx,   tbl[i].aidx);
            chk($sformatf("vec%0d.rej", i),   bus.reject,       int'(tbl[i].rej));
            chk($sformatf("vec%0d.err", i),   bus.exit_err,     int'(tbl[i].err));
            chk($sformatf("vec%0d.busy", i),  bus.busy,         int'(tbl[i].busy));
            chk($sformatf("vec%0d.door", i),  bus.door_open,    int'(tbl[i].busy));
        end

        // Fill the lot with spaced entries, then one more is rejected.
        do_reset();
        for (int i = 0; i < N; i++) begin
            drive(1, 0, 0);
            step();
            chk($sformatf("fill%0d.av", i),    bus.assign_valid, 1);
            chk($sformatf("fill%0d.aidx", i),  bus.assign_idx,   i);
            chk($sformatf("fill%0d.count", i), bus.count,        i + 1);
            drive(0, 0, 0);
            repeat (D) step();
        end
        drive(1, 0, 0);
        step();
        chk("full.rej",  bus.reject,       1);
        chk("full.full", bus.full,         1);
        chk("full.occ",  bus.occupancy,    8'hFF);
        chk("full.av",   bus.assign_valid, 0);
        chk("full.busy", bus.busy,         0);
        drive(0, 0, 0);
        step();
        chk("full.rej_pulse", bus.reject, 0);

        // Free spot 3 in a full lot; the next entry must reuse it.
        drive(0, 1, 3);
        step();
        chk("exit3.occ",   bus.occupancy, 8'hF7);
        chk("exit3.count", bus.count,     7);
        chk("exit3.full",  bus.full,      0);
        chk("exit3.busy",  bus.busy,      1);
        drive(0, 0, 0);
        repeat (D) step();
        drive(1, 0, 0);
        step();
        chk("reuse3.occ",  bus.occupancy,    8'hFF);
        chk("reuse3.av",   bus.assign_valid, 1);
        chk("reuse3.aidx", bus.assign_idx,   3);
        drive(0, 0, 0);

        // Entry held continuously: one accept every D+1 cycles, ascending spots.
        do_reset();
        drive(1, 0, 0);
        for (int c = 0; c < N * (D + 1); c++) begin
            step();
            chk($sformatf("held%0d.av", c), bus.assign_valid, int'(c % (D + 1) == 0));
            if (c % (D + 1) == 0)
                chk($sformatf("held%0d.aidx", c), bus.assign_idx, c / (D + 1));
        end

        // Reset during the second door cycle, then a fresh entry gets spot 0.
        do_reset();
        drive(1, 0, 0);
        step();
        drive(0, 0, 0);
        step();
        chk("midreset.busy_before", bus.busy, 1);
        do_reset();
        drive(1, 0, 0);
        step();
        chk("postreset.av",   bus.assign_valid, 1);
        chk("postreset.aidx", bus.assign_idx,   0);
        chk("postreset.occ",  bus.occupancy,    8'h01);
        drive(0, 0, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (c == 400) do_reset();
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, N - 1)));
            step();
            check_model($sformatf("rand%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
